// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32I constants and instruction-fetch controller types
// Purpose: opcode/funct3 constants used by the core and bench, the NOP word,
//          fetch FSM state and fault-cause enums, and the ECALL/EBREAK decoder.
// Ports:   none (package).
package riscv_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_PRIV    = 3'b000;

    // ADDI x0,x0,0
    localparam logic [31:0] NOP = 32'h00000013;

    typedef enum logic [2:0] {
        IDLE, LATCH, REQ, WAIT, ISSUE, EXEC, HALT, FAULT
    } fetch_state_t;

    typedef enum logic [1:0] {
        F_NONE, F_MISALIGN, F_TIMEOUT, F_ILLEGAL
    } fetch_fault_t;

    // ECALL (imm=0) or EBREAK (imm=1): imm in {0,1} means bits [31:21] are zero.
    function automatic logic is_halt_instr(input logic [31:0] instr);
        return (instr[6:0] == OPC_SYSTEM) && (instr[14:12] == F3_PRIV) &&
               (instr[11:7] == 5'd0) && (instr[19:15] == 5'd0) &&
               (instr[31:21] == 11'd0);
    endfunction

endpackage

// File: rtl/instr_fetch_ctrl.sv
// rtl/instr_fetch_ctrl.sv - instruction-fetch front end for the memory-less RV32I core
// Purpose: samples the core PC, fetches one word over a req/gnt/rvalid memory port,
//          presents it on command with a one-cycle run strobe, waits for done, repeats.
//          Stops on ECALL/EBREAK (halted) or on a fetch fault (fault, fault_cause).
// Ports:   clk, reset (sync, active-high); start; pc from the core;
//          mem_req/mem_addr/mem_gnt/mem_rvalid/mem_rdata instruction memory;
//          command/run/done core handshake; busy/halted/fault/fault_cause/retired status.
module instr_fetch_ctrl
    import riscv_pkg::*;
#(
    parameter int          ADDR_W      = 32,
    parameter int          TIMEOUT_CYC = 255,
    parameter logic [31:0] NOP_INSTR   = NOP
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [31:0]       pc,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    output logic [31:0]       command,
    output logic              run,
    input  logic              done,
    output logic              busy,
    output logic              halted,
    output logic              fault,
    output logic [1:0]        fault_cause,
    output logic [31:0]       retired
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);

    fetch_state_t state, next_state;
    fetch_fault_t cause, next_cause;
    logic [TW-1:0] timer;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        next_cause = F_NONE;
        case (state)
            IDLE: begin
                if (start) next_state = LATCH;
            end
            LATCH: begin
                if (pc[1:0] != 2'b00) begin
                    next_state = FAULT;
                    next_cause = F_MISALIGN;
                end else begin
                    next_state = REQ;
                end
            end
            REQ: begin
                if (mem_gnt) next_state = WAIT;
            end
            WAIT: begin
                // A response in the final timer cycle still wins over the timeout.
                if (mem_rvalid) begin
                    if (mem_rdata[1:0] != 2'b11) begin
                        next_state = FAULT;
                        next_cause = F_ILLEGAL;
                    end else begin
                        next_state = ISSUE;
                    end
                end else if (timer == TIMER_LAST) begin
                    next_state = FAULT;
                    next_cause = F_TIMEOUT;
                end
            end
            ISSUE: next_state = EXEC;
            EXEC: begin
                if (done) next_state = is_halt_instr(command) ? HALT : LATCH;
            end
            HALT:    next_state = HALT;
            FAULT:   next_state = FAULT;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_addr <= '0;
            command  <= NOP_INSTR;
            retired  <= '0;
            timer    <= '0;
            cause    <= F_NONE;
        end else begin
            if (state == LATCH) mem_addr <= pc[ADDR_W-1:0];

            if (state == REQ && mem_gnt) begin
                timer <= '0;
            end else if (state == WAIT && !mem_rvalid) begin
                timer <= timer + TW'(1);
            end

            if (state == WAIT && mem_rvalid) command <= mem_rdata;

            if (state == EXEC && done) retired <= retired + 32'd1;

            if (state != FAULT && next_state == FAULT) cause <= next_cause;
        end
    end

    assign mem_req     = (state == REQ);
    assign run         = (state == ISSUE);
    assign busy        = (state == LATCH) || (state == REQ) || (state == WAIT) ||
                         (state == ISSUE) || (state == EXEC);
    assign halted      = (state == HALT);
    assign fault       = (state == FAULT);
    assign fault_cause = cause;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// tb/tb_instr_fetch_ctrl.sv - self-checking bench for instr_fetch_ctrl
module tb_instr_fetch_ctrl;

    localparam int TMO = 8;

    typedef enum int {O_OK, O_HALT, O_MIS, O_TMO, O_ILL} outcome_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] rdata;
        int          gd;
        int          rd;
        int          dd;
        outcome_t    exp;
        logic [31:0] exp_ret;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] pc;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [31:0] command;
    logic        run;
    logic        done;
    logic        busy;
    logic        halted;
    logic        fault;
    logic [1:0]  fault_cause;
    logic [31:0] retired;

    int total = 0;
    int bad   = 0;
    int run_cnt = 0;
    int req_cnt = 0;

    instr_fetch_ctrl #(.ADDR_W(32), .TIMEOUT_CYC(TMO), .NOP_INSTR(32'h00000013)) dut (
        .clk(clk), .reset(reset), .start(start), .pc(pc),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .command(command), .run(run), .done(done),
        .busy(busy), .halted(halted), .fault(fault),
        .fault_cause(fault_cause), .retired(retired)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (run) run_cnt++;
        if (mem_req) req_cnt++;
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Outcome of one fetch from the architectural rules alone.
    function automatic outcome_t predict(input logic [31:0] p, input logic [31:0] w, input int rd);
        if (p % 4 != 0) return O_MIS;
        if (rd >= TMO) return O_TMO;
        if (w % 4 != 3) return O_ILL;
        if (w == 32'h00000073 || w == 32'h00100073) return O_HALT;
        return O_OK;
    endfunction

    task automatic do_reset;
        reset = 1'b1; start = 1'b0; pc = '0; mem_gnt = 1'b0;
        mem_rvalid = 1'b0; mem_rdata = '0; done = 1'b0;
        tick; tick;
        reset = 1'b0;
    endtask

    // Leaves the DUT in LATCH at the sampling point.
    task automatic begin_prog;
        start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    // Entry: DUT is in LATCH. Exit (non-terminal): DUT is in LATCH again.
    task automatic run_one(input logic [31:0] pcv, input logic [31:0] rdata,
                           input int gd, input int rd, input int dd, input bit glitch,
                           input outcome_t exp, input logic [31:0] exp_ret);
        int runs0;
        int reqs0;
        logic stable;
        runs0 = run_cnt;
        reqs0 = req_cnt;
        pc = pcv;
        tick;
        if (exp == O_MIS) begin
            check("mis_fault", fault, 1);
            check("mis_cause", fault_cause, 2'b01);
            check("mis_busy", busy, 0);
            check("mis_noreq", req_cnt - reqs0, 0);
            return;
        end
        check("req", mem_req, 1);
        check("req_addr", mem_addr, pcv);
        stable = 1'b1;
        repeat (gd) begin
            tick;
            if (mem_req !== 1'b1 || mem_addr !== pcv) stable = 1'b0;
        end
        if (gd > 0) check("gnt_stall_hold", stable, 1);
        mem_gnt = 1'b1;
        tick;
        mem_gnt = 1'b0;
        check("wait_noreq", mem_req, 0);
        check("req_cycles", req_cnt - reqs0, gd + 1);
        if (exp == O_TMO) begin
            repeat (TMO - 1) tick;
            check("tmo_early", fault, 0);
            tick;
            check("tmo_fault", fault, 1);
            check("tmo_cause", fault_cause, 2'b10);
            check("tmo_busy", busy, 0);
            check("tmo_norun", run_cnt - runs0, 0);
            return;
        end
        repeat (rd) tick;
        mem_rvalid = 1'b1;
        mem_rdata = rdata;
        tick;
        mem_rvalid = 1'b0;
        mem_rdata = $urandom;
        check("cmd", command, rdata);
        if (exp == O_ILL) begin
            check("ill_fault", fault, 1);
            check("ill_cause", fault_cause, 2'b11);
            check("ill_busy", busy, 0);
            tick;
            check("ill_norun", run_cnt - runs0, 0);
            check("ill_cmd_hold", command, rdata);
            return;
        end
        check("run_pulse", run, 1);
        done = glitch;
        tick;
        done = 1'b0;
        check("run_low", run, 0);
        check("exec_busy", busy, 1);
        repeat (dd) tick;
        check("ret_before", retired, exp_ret - 32'd1);
        done = 1'b1;
        tick;
        done = 1'b0;
        check("retired", retired, exp_ret);
        check("run_cycles", run_cnt - runs0, 1);
        if (exp == O_HALT) begin
            check("halt_flag", halted, 1);
            check("halt_busy", busy, 0);
            start = 1'b1;
            tick;
            start = 1'b0;
            repeat (3) tick;
            check("halt_hold", halted, 1);
            check("halt_noreq", req_cnt - reqs0, gd + 1);
            check("halt_cmd", command, rdata);
        end else begin
            check("not_halted", halted, 0);
            check("latch_busy", busy, 1);
        end
    endtask

    initial begin
        vec_t vecs[$];
        outcome_t o;
        logic [31:0] rp;
        logic [31:0] rw;
        logic [31:0] eret;
        int r;
        int rdl;

        vecs.push_back('{32'h00000000, 32'h01000093, 1, 1, 1, O_OK,   32'd1});
        vecs.push_back('{32'h00000010, 32'h00000013, 5, 0, 0, O_OK,   32'd1});
        vecs.push_back('{32'h00000022, 32'h00000013, 0, 0, 0, O_MIS,  32'd0});
        vecs.push_back('{32'h00000004, 32'h00000013, 0, 8, 0, O_TMO,  32'd0});
        vecs.push_back('{32'h00000004, 32'h00500093, 0, 7, 0, O_OK,   32'd1});
        vecs.push_back('{32'h00000008, 32'h00000010, 0, 1, 0, O_ILL,  32'd0});
        vecs.push_back('{32'h0000000c, 32'h00100073, 0, 1, 1, O_HALT, 32'd1});
        vecs.push_back('{32'h0000000c, 32'h00000073, 2, 0, 3, O_HALT, 32'd1});
        vecs.push_back('{32'h0000000c, 32'h00200073, 0, 0, 0, O_OK,   32'd1});
        vecs.push_back('{32'h0000000c, 32'h00000473, 0, 2, 0, O_OK,   32'd1});
        vecs.push_back('{32'h00003ffc, 32'h00008067, 3, 3, 2, O_OK,   32'd1});

        do_reset;
        check("rst_req", mem_req, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_run", run, 0);
        check("rst_busy", busy, 0);
        check("rst_halted", halted, 0);
        check("rst_fault", fault, 0);
        check("rst_cause", fault_cause, 0);
        check("rst_retired", retired, 0);
        check("rst_cmd", command, 32'h00000013);

        foreach (vecs[i]) begin
            do_reset;
            begin_prog;
            check("start_busy", busy, 1);
            run_one(vecs[i].pc, vecs[i].rdata, vecs[i].gd, vecs[i].rd, vecs[i].dd, 1'b0,
                    vecs[i].exp, vecs[i].exp_ret);
        end

        // Back-to-back fetches: second request must use the new PC.
        do_reset;
        begin_prog;
        run_one(32'h0, 32'h01000093, 1, 1, 1, 1'b0, O_OK, 32'd1);
        run_one(32'h4, 32'h00100073, 0, 0, 0, 1'b1, O_HALT, 32'd2);

        // Reset during WAIT, then a stale response lands in IDLE.
        do_reset;
        begin_prog;
        pc = 32'h0;
        tick;
        mem_gnt = 1'b1;
        tick;
        mem_gnt = 1'b0;
        tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata = 32'h01000093;
        tick;
        mem_rvalid = 1'b0;
        tick;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_cmd", command, 32'h00000013);
        check("mid_rst_run", run, 0);
        check("mid_rst_ret", retired, 0);
        check("mid_rst_req", mem_req, 0);
        check("mid_rst_fault", fault, 0);

        // Randomized programs against the rule-level model.
        for (int p = 0; p < 40; p++) begin
            do_reset;
            begin_prog;
            eret = 32'd0;
            for (int k = 0; k < 12; k++) begin
                rp = $urandom;
                if ($urandom_range(0, 9) != 0) rp = rp & ~32'd3;
                r = $urandom_range(0, 9);
                if (r == 0)      rw = 32'h00000073;
                else if (r == 1) rw = 32'h00100073;
                else if (r == 2) rw = $urandom;
                else             rw = $urandom | 32'd3;
                rdl = ($urandom_range(0, 19) == 0) ? $urandom_range(8, 9) : $urandom_range(0, 7);
                o = predict(rp, rw, rdl);
                if (o == O_OK || o == O_HALT) eret = eret + 32'd1;
                run_one(rp, rw, $urandom_range(0, 3), rdl, $urandom_range(0, 3),
                        1'($urandom_range(0, 1)), o, eret);
                if (o != O_OK) break;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_fetch_ctrl.md
Name: instr_fetch_ctrl

Overview:
Instruction-fetch front end that feeds the memory-less RV32I core (RISC_V_Processor_V0).
- Samples the core's current PC and reads one word from a request/grant/response instruction memory.
- Presents the word on `command` and pulses `run`, then waits for the core's `done` before fetching the next instruction.
- Stops on ECALL/EBREAK or on a fetch fault.

Parameters:
- ADDR_W, 32, width of the instruction-memory address.
- TIMEOUT_CYC, 255, maximum number of WAIT cycles allowed before a response-timeout fault.
- NOP_INSTR, 32'h00000013, `command` value after reset (ADDI x0,x0,0).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin fetching; sampled in IDLE only.
- pc  in  32  current PC from the core (regValues[38]).
- mem_req  out  1  fetch request.
- mem_addr  out  ADDR_W  fetch address (word-aligned).
- mem_gnt  in  1  request accepted.
- mem_rvalid  in  1  response data valid.
- mem_rdata  in  32  instruction word.
- command  out  32  instruction presented to the core.
- run  out  1  one-cycle execute strobe to the core.
- done  in  1  core finished the current instruction.
- busy  out  1  controller active.
- halted  out  1  ECALL/EBREAK retired.
- fault  out  1  fetch fault, sticky.
- fault_cause  out  2  00 none, 01 misaligned PC, 10 response timeout, 11 illegal encoding (bits[1:0]≠11).
- retired  out  32  count of instructions retired.

Behaviour:
- Reset (synchronous, active-high): state=IDLE; mem_req=0, mem_addr=0, run=0, busy=0, halted=0, fault=0, fault_cause=00, retired=0, command=NOP_INSTR, timer=0. Reset overrides every other input in every state.
- Timing: all outputs are registered or decoded from the state register; no combinational path from inputs to outputs.
- State machine, one transition per clock:
  - IDLE: start=1 → LATCH.
  - LATCH: fetch_pc ← pc.
    - If pc[1:0]≠00 → FAULT with cause 01.
    - Otherwise → REQ.
  - REQ: mem_req=1, mem_addr=fetch_pc[ADDR_W-1:0].
    - Request and address are held stable until mem_gnt=1, for an unbounded stall.
    - mem_gnt=1 → WAIT, timer←0.
  - WAIT: mem_req=0.
    - mem_rvalid=1: command←mem_rdata. If mem_rdata[1:0]≠11 → FAULT with cause 11, else → ISSUE.
    - No rvalid: timer++. If timer reaches TIMEOUT_CYC-1 → FAULT with cause 10 (TIMEOUT_CYC WAIT cycles total).
    - mem_rvalid takes priority over timeout in the same cycle.
  - ISSUE: run=1 for exactly this cycle → EXEC.
  - EXEC: run=0; wait for done.
    - On done: retired++ (wraps at 2^32).
    - If command is ECALL/EBREAK → HALT, else → LATCH.
    - ECALL/EBREAK is recognised by: opcode 1110011, funct3 000, rd=0, rs1=0, imm[31:20] ∈ {0,1}.
  - HALT: halted=1; absorbing until reset; start ignored.
  - FAULT: fault=1, fault_cause held; absorbing until reset.
- mem_rvalid outside WAIT is ignored. This covers a late response after reset, which lands in IDLE.
- done outside EXEC is ignored, including done in the ISSUE cycle. The core must respond no earlier than the cycle after run.
- command holds its captured value through ISSUE, EXEC, HALT and FAULT. It changes only on rvalid capture or reset.
- busy=1 in LATCH, REQ, WAIT, ISSUE and EXEC; 0 in IDLE, HALT and FAULT.
- Throughput: at least 5 cycles per instruction (LATCH, REQ, WAIT, ISSUE, EXEC), with gnt and rvalid each arriving after one cycle and done arriving one cycle after run.
- Sampling PC in LATCH, one cycle after done, gives the core one cycle to commit its PC update for JAL/JALR/branches.

Decomposition:
- Shared package riscv_pkg:
  - opcode constants (SYSTEM=7'b1110011, etc.) and the funct3 constants already used by the core and bench;
  - NOP constant;
  - fetch_state_t enum {IDLE, LATCH, REQ, WAIT, ISSUE, EXEC, HALT, FAULT};
  - fetch_fault_t enum {F_NONE, F_MISALIGN, F_TIMEOUT, F_ILLEGAL}.
- Single module; no sub-module. The timeout counter and retire counter are inline.

Test Plan:
1. Basic fetch:
   - Stimulus: reset, then start with pc=0; gnt the cycle after mem_req; rvalid 2 cycles later with rdata=0x01000093; done 2 cycles after run; pc then driven to 4.
   - Response: mem_addr=0, command=0x01000093, run high exactly 1 cycle, retired=1, next request at mem_addr=4.
2. Grant stall:
   - Stimulus: mem_gnt held low 5 cycles with pc=0x10.
   - Response: mem_req=1 and mem_addr=0x10 stable for all 5 cycles; a single WAIT entry after gnt.
3. Misaligned PC:
   - Stimulus: pc=0x22 at start.
   - Response: fault=1, fault_cause=01, mem_req never asserted, busy=0.
4. Timeout and illegal encoding:
   - Stimulus: TIMEOUT_CYC=8, no rvalid after gnt.
   - Response: fault_cause=10 after the 8th WAIT cycle.
   - Separate run: rdata=0x00000010 gives fault_cause=11 and run never pulses.
5. EBREAK:
   - Stimulus: rdata=0x00100073, then done.
   - Response: halted=1, busy=0, retired incremented, no further mem_req; start pulse afterwards ignored.
   - Repeat with 0x00000073 (ECALL): same result.
6. Reset mid-fetch:
   - Stimulus: reset asserted in WAIT, then rvalid arrives the cycle after reset.
   - Response: state IDLE, command=0x00000013, run=0, retired=0, response ignored.
